pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It drives the enable and clear inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB enable/reset flip-flop banks. It resolves four conditions: load-use hazards, taken-branch flushes, the multi-cycle mul/div unit, and external memory wait. It also runs a post-reset boot flush, and keeps its own state: the boot counter, the mul/div busy counter and optional performance counters.

## Interface
- `MUL_LAT`, default 4: mul busy cycles (1..63).
- `DIV_LAT`, default 32: div busy cycles (1..63).
- `BOOT_CYC`, default 2: post-reset flush cycles (1..15).
- `clk` in 1: single clock; all state on posedge.
- `r_n` in 1: reset, asynchronous, active-low.
- `id_rs`, `id_rt` in 5 each: source registers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` in 1 each: ID instruction reads that source.
- `ex_memread` in 1: instruction in EX is a load.
- `ex_rt` in 5: load destination in EX.
- `ex_branch_taken` in 1: branch/jump resolved taken in EX.
- `id_md_start` in 1: ID instruction is mult/div.
- `id_md_div` in 1: 1 = div, 0 = mult.
- `id_md_read` in 1: ID instruction is mfhi/mflo.
- `ext_stall` in 1: memory wait; freeze the whole pipeline.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1 each: stage enables.
- `ifid_clr`, `idex_clr`, `exmem_clr` out 1 each: stage synchronous clears (flop reset has priority over enable).
- `md_busy` out 1: mul/div unit running.
- `stall_cnt`, `flush_cnt` out 16 each: performance counters (see Configuration).

## Operation
- FSM states:
  - BOOT: entered on reset. `boot_cnt` loads BOOT_CYC-1 and decrements each cycle. Move to RUN when it reaches 0.
  - RUN: permanent state until the next reset.
- BOOT outputs:
  - all `*_clr`=1, all `*_en`=1, `pc_en`=0.
  - `id_md_start` is ignored.
- Mul/div counter `md_cnt` (6 bits):
  - `md_cnt` loads MUL_LAT or DIV_LAT on an accepted start.
  - Otherwise it decrements while nonzero. It also decrements during `ext_stall`.
  - `md_busy` = (`md_cnt` != 0).
  - A start is accepted only when the ID stage advances into EX: RUN, no `ext_stall`, no flush, no ID stall.
- Hazard terms in RUN:
  - lu = `ex_memread` & `ex_rt`!=0 & ((`id_uses_rs` & `id_rs`==`ex_rt`) | (`id_uses_rt` & `id_rt`==`ex_rt`)).
  - md = `md_busy` & (`id_md_start` | `id_md_read`).
  - id_stall = lu | md.
- Output priority in RUN, highest first:
  1. `ext_stall`: all `*_en`=0, all `*_clr`=0. A branch held in EX is acted on after release.
  2. `ex_branch_taken`: `pc_en`=1, `ifid_clr`=1, `idex_clr`=1, other enables 1. Overrides id_stall and squashes an ID start.
  3. id_stall: `pc_en`=0, `ifid_en`=0, `idex_clr`=1 (bubble), `exmem_en`=`memwb_en`=1.
  4. Otherwise all `*_en`=1 and all `*_clr`=0.
- `exmem_clr` is 1 only in BOOT.
- Reset mid-operation: reset asynchronously returns to BOOT, with `md_cnt`=0 and the counters cleared.

## Timing
- All outputs are combinational from state plus same-cycle inputs. There is no added latency.
- Values during reset:
  - `pc_en`=0, all other `*_en`=1, all `*_clr`=1.
  - `md_busy`=0, `stall_cnt`=`flush_cnt`=0.
- After `r_n` rises: BOOT lasts exactly BOOT_CYC cycles. The first fetch (`pc_en`=1) occurs in cycle BOOT_CYC.
- A start accepted at edge k gives `md_busy`=1 from k+1 for exactly LAT cycles.
  - An `id_md_read` in ID during that window stalls; it proceeds in the cycle `md_busy` falls.
  - A back-to-back start stalls until `md_busy`=0, then is accepted.
- Load-use produces exactly one bubble cycle per hazard, absent other events.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cnt` increments in each RUN cycle with id_stall & !`ex_branch_taken` & !`ext_stall`.
  - `flush_cnt` increments in each RUN cycle with `ex_branch_taken` & !`ext_stall`.
  - Both saturate at 16'hFFFF.
- `PIPE_CTRL_PERF_EN` undefined: no counter flops; `stall_cnt` and `flush_cnt` are tied to 0.

## Test plan
- Reset released with BOOT_CYC=2 → 2 cycles with all clears=1 and `pc_en`=0; cycle 3 has `pc_en`=1 and clears=0.
- `ex_memread`=1, `ex_rt`=5, `id_rs`=5, `id_uses_rs`=1 → one cycle of `pc_en`=0, `ifid_en`=0, `idex_clr`=1; `stall_cnt` becomes 1. Same with `ex_rt`=0 → no stall.
- Mult accepted, then mfhi in ID → `md_busy` high for 4 cycles; stall for 4 cycles; mfhi proceeds on cycle 5. Div → 32 cycles.
- `ex_branch_taken`=1 coincident with a load-use hazard → `ifid_clr`=`idex_clr`=1, `pc_en`=1, no stall; `flush_cnt` increments and `stall_cnt` does not.
- `ext_stall`=1 for 3 cycles during a branch → all enables=0 and clears=0 for those cycles; the flush occurs on the first cycle after release; `md_cnt` keeps decrementing throughout.
- `r_n` asserted mid-div (`md_cnt`=17) → `md_busy`=0 immediately and the FSM is in BOOT; with PERF enabled, both counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: boot flush, load-use, branch flush, mul/div interlock, memory wait.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined; otherwise stall_cnt/flush_cnt read 0.
module pipe_hazard_ctrl #(
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 32,
    parameter int BOOT_CYC = 2
) (
    input  logic        clk,
    input  logic        r_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        id_md_start,
    input  logic        id_md_div,
    input  logic        id_md_read,
    input  logic        ext_stall,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_clr,
    output logic        idex_clr,
    output logic        exmem_clr,
    output logic        md_busy,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic {ST_BOOT, ST_RUN} state_t;

    state_t      r_state;
    logic [3:0]  r_boot_cnt;
    logic [5:0]  r_md_cnt;

    logic        w_run;
    logic        w_lu;
    logic        w_md;
    logic        w_id_stall;
    logic        w_md_accept;

    assign w_run      = (r_state == ST_RUN);
    assign md_busy    = (r_md_cnt != 6'd0);
    assign w_lu       = ex_memread && (ex_rt != 5'd0) &&
                        ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
    assign w_md       = md_busy && (id_md_start || id_md_read);
    assign w_id_stall = w_lu || w_md;
    // A start only counts when the instruction really moves from ID into EX.
    assign w_md_accept = w_run && !ext_stall && !ex_branch_taken && !w_id_stall && id_md_start;

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            r_state    <= ST_BOOT;
            r_boot_cnt <= 4'(BOOT_CYC - 1);
        end else begin
            case (r_state)
                ST_BOOT: begin
                    if (r_boot_cnt == 4'd0) r_state <= ST_RUN;
                    else                    r_boot_cnt <= r_boot_cnt - 4'd1;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // The unit keeps running through ext_stall, so the countdown is not gated.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n)                   r_md_cnt <= 6'd0;
        else if (w_md_accept)       r_md_cnt <= id_md_div ? 6'(DIV_LAT) : 6'(MUL_LAT);
        else if (r_md_cnt != 6'd0)  r_md_cnt <= r_md_cnt - 6'd1;
    end

    always_comb begin
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        idex_en   = 1'b1;
        exmem_en  = 1'b1;
        memwb_en  = 1'b1;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        exmem_clr = 1'b0;
        if (!w_run) begin
            pc_en     = 1'b0;
            ifid_clr  = 1'b1;
            idex_clr  = 1'b1;
            exmem_clr = 1'b1;
        end else if (ext_stall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
        end else if (w_id_stall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            r_stall_cnt <= 16'h0;
            r_flush_cnt <= 16'h0;
        end else if (w_run && !ext_stall) begin
            if (ex_branch_taken) begin
                if (r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'h1;
            end else if (w_id_stall) begin
                if (r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'h1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 16'h0;
    assign flush_cnt = 16'h0;
`endif

endmodule
